// File: rtl/mod_sub_stream_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mod_sub_stream_pkg
// Brief    : Shared defaults and FSM state type for the streaming modular subtractor.
// Revision : 1.0
// ============================================================================
package mod_sub_stream_pkg;

  localparam int c_DATA_WIDTH = 32;
  localparam int c_N_WIDTH    = 8;
  localparam int c_N_COEF     = 256;
  localparam int c_LATENCY    = 2;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

endpackage
`default_nettype wire

// File: rtl/mod_sub_core.sv
`default_nettype none
// ============================================================================
// Module   : mod_sub_core
// Brief    : Single conditional +Q correction of a signed difference.
// Revision : 1.0
// ============================================================================
module mod_sub_core
  import mod_sub_stream_pkg::*;
#(
  parameter int DATA_WIDTH = c_DATA_WIDTH
) (
  input  logic [DATA_WIDTH:0]   i_d,
  input  logic [DATA_WIDTH-1:0] i_q,
  output logic [DATA_WIDTH-1:0] o_res
);

  // Sign bit of the widened difference selects the wrap-around correction.
  assign o_res = i_d[DATA_WIDTH] ? (i_d[DATA_WIDTH-1:0] + i_q) : i_d[DATA_WIDTH-1:0];

endmodule
`default_nettype wire

// File: rtl/mod_sub_stream.sv
`default_nettype none
// ============================================================================
// Module   : mod_sub_stream
// Brief    : Two-stage streaming (a - b) mod Q over one polynomial per job.
// Revision : 1.0
// ============================================================================
module mod_sub_stream
  import mod_sub_stream_pkg::*;
#(
  parameter int DATA_WIDTH = c_DATA_WIDTH,
  parameter int N_WIDTH    = c_N_WIDTH,
  parameter int N_COEF     = c_N_COEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic [DATA_WIDTH-1:0] i_q,
  input  logic                  i_in_valid,
  output logic                  o_in_ready,
  input  logic [DATA_WIDTH-1:0] i_a,
  input  logic [DATA_WIDTH-1:0] i_b,
  output logic                  o_out_valid,
  input  logic                  i_out_ready,
  output logic [DATA_WIDTH-1:0] o_out,
  output logic [N_WIDTH-1:0]    o_out_idx,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam int CNT_W = N_WIDTH + 1;
  localparam logic [CNT_W-1:0] c_CNT_FULL = CNT_W'(N_COEF);
  localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(N_COEF - 1);

  state_e                r_state;
  state_e                w_state_nxt;
  logic [DATA_WIDTH-1:0] r_q;
  logic [CNT_W-1:0]      r_in_cnt;
  logic [CNT_W-1:0]      r_out_cnt;
  logic                  r_s1_valid;
  logic [DATA_WIDTH:0]   r_s1_d;
  logic [N_WIDTH-1:0]    r_s1_idx;
  logic                  r_out_valid;
  logic [DATA_WIDTH-1:0] r_out;
  logic [N_WIDTH-1:0]    r_out_idx;
  logic                  r_done;

  logic                  w_busy;
  logic                  w_start_acc;
  logic                  w_s2_adv;
  logic                  w_s1_adv;
  logic                  w_in_ready;
  logic                  w_in_fire;
  logic                  w_out_fire;
  logic                  w_last_fire;
  logic [DATA_WIDTH:0]   w_d;
  logic [DATA_WIDTH-1:0] w_res;

  assign w_busy      = (r_state == ST_BUSY);
  assign w_start_acc = !w_busy && i_start;
  assign w_s2_adv    = !r_out_valid || i_out_ready;
  assign w_s1_adv    = !r_s1_valid || w_s2_adv;
  assign w_in_ready  = w_busy && (r_in_cnt < c_CNT_FULL) && w_s1_adv;
  assign w_in_fire   = i_in_valid && w_in_ready;
  assign w_out_fire  = r_out_valid && i_out_ready;
  assign w_last_fire = w_out_fire && (r_out_cnt == c_CNT_LAST);
  assign w_d         = {i_a[DATA_WIDTH-1], i_a} - {i_b[DATA_WIDTH-1], i_b};

  mod_sub_core #(.DATA_WIDTH(DATA_WIDTH)) u_core (
    .i_d   (r_s1_d),
    .i_q   (r_q),
    .o_res (w_res)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (i_start)     w_state_nxt = ST_BUSY;
      ST_BUSY: if (w_last_fire) w_state_nxt = ST_IDLE;
      default:                  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q         <= '0;
      r_in_cnt    <= '0;
      r_out_cnt   <= '0;
      r_s1_valid  <= 1'b0;
      r_s1_d      <= '0;
      r_s1_idx    <= '0;
      r_out_valid <= 1'b0;
      r_out       <= '0;
      r_out_idx   <= '0;
      r_done      <= 1'b0;
    end else begin
      r_done <= w_last_fire;
      if (w_start_acc) begin
        r_q       <= i_q;
        r_in_cnt  <= '0;
        r_out_cnt <= '0;
      end else begin
        if (w_in_fire)  r_in_cnt  <= r_in_cnt + 1'b1;
        if (w_out_fire) r_out_cnt <= r_out_cnt + 1'b1;
      end
      if (w_s1_adv) begin
        r_s1_valid <= w_in_fire;
        if (w_in_fire) begin
          r_s1_d   <= w_d;
          r_s1_idx <= r_in_cnt[N_WIDTH-1:0];
        end
      end
      // Stage 2 holds its result untouched while the consumer stalls.
      if (w_s2_adv) begin
        r_out_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_out     <= w_res;
          r_out_idx <= r_s1_idx;
        end
      end
    end
  end

  assign o_in_ready  = w_in_ready;
  assign o_out_valid = r_out_valid;
  assign o_out       = r_out;
  assign o_out_idx   = r_out_idx;
  assign o_busy      = w_busy;
  assign o_done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_mod_sub_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_mod_sub_stream
// Brief    : Directed and randomized self-checking bench for mod_sub_stream.
// Revision : 1.0
// ============================================================================
module tb_mod_sub_stream;
  import mod_sub_stream_pkg::*;

  localparam int DW = 32;
  localparam int NW = 8;
  localparam int NC = 4;

  logic          clk;
  logic          rst;
  logic          i_start;
  logic [DW-1:0] i_q;
  logic          i_in_valid;
  logic          o_in_ready;
  logic [DW-1:0] i_a;
  logic [DW-1:0] i_b;
  logic          o_out_valid;
  logic          i_out_ready;
  logic [DW-1:0] o_out;
  logic [NW-1:0] o_out_idx;
  logic          o_busy;
  logic          o_done;

  int total = 0;
  int bad   = 0;
  logic [31:0] ga  [NC];
  logic [31:0] gb  [NC];
  logic [31:0] cap [NC];

  mod_sub_stream #(.DATA_WIDTH(DW), .N_WIDTH(NW), .N_COEF(NC)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_start     (i_start),
    .i_q         (i_q),
    .i_in_valid  (i_in_valid),
    .o_in_ready  (o_in_ready),
    .i_a         (i_a),
    .i_b         (i_b),
    .o_out_valid (o_out_valid),
    .i_out_ready (i_out_ready),
    .o_out       (o_out),
    .o_out_idx   (o_out_idx),
    .o_busy      (o_busy),
    .o_done      (o_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ref_sub(input longint a, input longint b, input longint q);
    longint r;
    r = (a - b) % q;
    r = (r + q) % q;
    return r[31:0];
  endfunction

  task automatic set_pairs(input logic [31:0] a0, b0, a1, b1, a2, b2, a3, b3);
    ga[0] = a0; gb[0] = b0; ga[1] = a1; gb[1] = b1;
    ga[2] = a2; gb[2] = b2; ga[3] = a3; gb[3] = b3;
  endtask

  // Runs one job; returns in the cycle where done is high so a caller may chain a start.
  task automatic run_job(input logic [31:0] q, input int mode, input bit noise);
    logic [31:0] expv [NC];
    int acc = 0, head = 0, t = 0, last_hs = -10, first_acc = -1, first_ov = -1;
    bit fin = 0, fire_in, fire_out;
    logic [31:0] outv;
    i_q = q;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    check("busy_after_start", o_busy, 1);
    while (!fin && t < 200) begin
      i_in_valid = (acc < NC);
      i_a = ga[(acc < NC) ? acc : 0];
      i_b = gb[(acc < NC) ? acc : 0];
      case (mode)
        0:       i_out_ready = 1'b1;
        1:       i_out_ready = (t % 3 == 0);
        default: i_out_ready = $urandom_range(1, 0) == 1;
      endcase
      if (noise) begin
        i_start = (t == 2);
        if (t == 2) i_q = 32'd7;
      end
      #1;
      if (o_out_valid) begin
        if (first_ov < 0) first_ov = t;
        if (head < NC) begin
          check("out_value", o_out, expv[head]);
          check("out_idx", o_out_idx, 64'(head));
        end else begin
          check("extra_out", o_out_valid, 0);
        end
      end
      check("done_timing", o_done, (t == last_hs + 1));
      if (o_done) begin
        check("busy_at_done", o_busy, 0);
        fin = 1;
      end else begin
        if ((acc - head) == 2 && !i_out_ready) check("in_ready_full", o_in_ready, 0);
        if ((acc - head) == 0 && acc < NC) check("in_ready_empty", o_in_ready, 1);
        fire_in  = i_in_valid && o_in_ready;
        fire_out = o_out_valid && i_out_ready;
        outv = o_out;
        tick();
        t++;
        if (fire_in) begin
          expv[acc] = ref_sub(longint'(ga[acc]), longint'(gb[acc]), longint'(q));
          if (first_acc < 0) first_acc = t - 1;
          acc++;
        end
        if (fire_out) begin
          if (head < NC) cap[head] = outv;
          head++;
          if (head == NC) last_hs = t - 1;
        end
      end
    end
    i_start = 1'b0;
    i_in_valid = 1'b0;
    if (!fin) begin
      total++;
      bad++;
      $error("FAIL job_timeout observed=%0d results expected=%0d", head, NC);
    end
    check("first_latency", 64'(first_ov - first_acc), 64'(c_LATENCY));
  endtask

  initial begin
    logic [31:0] qb;
    rst = 1'b1; i_start = 1'b0; i_q = '0; i_in_valid = 1'b0;
    i_a = '0; i_b = '0; i_out_ready = 1'b1;
    tick();
    tick();
    check("rst_out_valid", o_out_valid, 0);
    check("rst_busy", o_busy, 0);
    check("rst_done", o_done, 0);
    check("rst_in_ready", o_in_ready, 0);
    check("rst_out", o_out, 0);
    check("rst_out_idx", o_out_idx, 0);
    rst = 1'b0;
    tick();

    set_pairs(5, 3, 3, 5, 0, 0, 0, 16);
    run_job(32'd17, 0, 0);
    check("j1_r0", cap[0], 2);
    check("j1_r1", cap[1], 15);
    check("j1_r2", cap[2], 0);
    check("j1_r3", cap[3], 1);

    // Chained start lands in the done cycle of the previous job.
    qb = 32'h4000_0003;
    set_pairs(0, qb - 1, qb - 1, 0, qb - 1, qb - 1, 0, 1);
    run_job(qb, 1, 0);
    check("sign_r0", cap[0], 1);
    check("sign_r1", cap[1], 32'h4000_0002);
    check("sign_r2", cap[2], 0);
    check("sign_r3", cap[3], 32'h4000_0002);

    set_pairs(1, 22, 22, 1, 10, 10, 0, 5);
    run_job(32'd23, 2, 1);
    check("noise_r0", cap[0], 2);
    check("noise_r1", cap[1], 21);
    check("noise_r2", cap[2], 0);
    check("noise_r3", cap[3], 18);
    tick();
    check("no_extra_done", o_done, 0);
    check("idle_after_job", o_busy, 0);

    i_q = 32'd17; i_start = 1'b1;
    tick();
    i_start = 1'b0; i_out_ready = 1'b0; i_in_valid = 1'b1; i_a = 5; i_b = 3;
    tick();
    i_a = 3; i_b = 5;
    tick();
    i_in_valid = 1'b0;
    #1;
    check("pre_abort_valid", o_out_valid, 1);
    check("pre_abort_out", o_out, 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_out_valid", o_out_valid, 0);
    check("abort_busy", o_busy, 0);
    check("abort_done", o_done, 0);
    check("abort_in_ready", o_in_ready, 0);
    check("abort_out", o_out, 0);
    check("abort_idx", o_out_idx, 0);
    i_out_ready = 1'b1;
    tick();
    check("abort_no_done", o_done, 0);
    set_pairs(16, 0, 0, 1, 8, 9, 9, 8);
    run_job(32'd17, 0, 0);
    check("post_r0", cap[0], 16);
    check("post_r1", cap[1], 16);
    check("post_r2", cap[2], 16);
    check("post_r3", cap[3], 1);

    for (int j = 0; j < 250; j++) begin
      qb = $urandom_range(32'h7FFF_FFFF, 2);
      for (int k = 0; k < NC; k++) begin
        ga[k] = $urandom_range(qb - 1, 0);
        gb[k] = $urandom_range(qb - 1, 0);
      end
      run_job(qb, j % 3, 0);
    end
    tick();
    check("final_done_low", o_done, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
